// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding and fault cause codes.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    VALID,
    FAULT
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

endpackage

// File: rtl/adder.sv
// Constant-operand adder: y = a + B when M = 0, y = a - B when M = 1.
// Arithmetic wraps modulo 2^W.
module adder #(
  parameter int unsigned    W = 64,
  parameter logic [W-1:0]   B = '0,
  parameter bit             M = 1'b0
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  // Add or subtract the constant operand
  always_comb begin
    y = M ? (a - B) : (a + B);
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one request per instruction, waits for
// instruction memory with a bounded timeout, presents the captured word
// until downstream accepts it, then follows next_pc. Faults are terminal.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] next_pc,
  input  logic        inst_ready,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  output logic [63:0] out,
  output logic [63:0] PC4,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [63:0] retired_count
);

  // Counter only needs to reach TIMEOUT-1; the cycle that would hit
  // TIMEOUT is the one that raises the fault.
  localparam int unsigned   CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t          state, state_n;
  logic [63:0]     pc;
  logic [CW-1:0]   wait_cnt;
  logic            capture;
  logic            handshake;
  logic            misalign;
  logic            wait_expired;

  assign misalign  = (next_pc[1:0] != 2'b00);
  assign imem_addr = pc;
  assign out       = pc;

  adder #(
    .W (64),
    .B (64'd4),
    .M (1'b0)
  ) u_pc4 (
    .a (pc),
    .y (PC4)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and per-state output decode
  always_comb begin
    state_n      = state;
    imem_req     = 1'b0;
    inst_valid   = 1'b0;
    fault        = 1'b0;
    capture      = 1'b0;
    handshake    = 1'b0;
    wait_expired = 1'b0;
    case (state)
      IDLE:  state_n = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        state_n  = WAIT;
      end
      WAIT: begin
        if (imem_valid) begin
          capture = 1'b1;
          state_n = VALID;
        end else if (wait_cnt == LAST) begin
          wait_expired = 1'b1;
          state_n      = FAULT;
        end
      end
      VALID: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          handshake = 1'b1;
          state_n   = misalign ? FAULT : FETCH;
        end
      end
      FAULT:   fault   = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  // PC, instruction capture, wait counter, retire count and fault cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      inst          <= '0;
      wait_cnt      <= '0;
      retired_count <= '0;
      fault_cause   <= CAUSE_NONE;
    end else begin
      if (state == FETCH) begin
        wait_cnt <= '0;
      end else if (state == WAIT && !imem_valid && !wait_expired) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (capture) inst <= imem_rdata;
      if (handshake) begin
        pc            <= next_pc;
        retired_count <= retired_count + 64'd1;
        if (misalign) fault_cause <= CAUSE_MISALIGN;
      end
      if (wait_expired) fault_cause <= CAUSE_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected
// instruction/PC pairs pushed when imem responds and popped on inst_valid.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] next_pc;
  logic        inst_ready;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [63:0] out;
  logic [63:0] PC4;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [63:0] retired_count;

  int unsigned checks = 0;
  int unsigned passes = 0;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;
  exp_t sb[$];

  fetch_stage #(
    .RESET_PC (64'h0),
    .TIMEOUT  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .next_pc       (next_pc),
    .inst_ready    (inst_ready),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .out           (out),
    .PC4           (PC4),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .fault         (fault),
    .fault_cause   (fault_cause),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at the FETCH sample point; answers after 'delay' idle WAIT cycles
  task automatic serve(input int unsigned delay, input logic [31:0] data);
    logic [63:0] a;
    a = imem_addr;
    chk("serve_req", {63'd0, imem_req}, 64'd1);
    tick();
    for (int unsigned i = 0; i < delay; i++) begin
      chk("wait_no_fault", {63'd0, fault}, 64'd0);
      tick();
    end
    imem_valid = 1'b1;
    imem_rdata = data;
    sb.push_back('{data, a});
    tick();
    imem_valid = 1'b0;
    imem_rdata = '0;
  endtask

  // Bounded wait for inst_valid, then compare against the scoreboard head
  task automatic expect_out();
    exp_t e;
    int unsigned n = 0;
    while (inst_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("inst_valid_rise", {63'd0, inst_valid}, 64'd1);
    if (sb.size() == 0) begin
      checks++;
      $error("FAIL scoreboard: observed empty queue, required one entry");
    end else begin
      e = sb.pop_front();
      chk("sb_inst", {32'd0, inst}, {32'd0, e.inst});
      chk("sb_out", out, e.pc);
      chk("sb_pc4", PC4, e.pc + 64'd4);
    end
  endtask

  task automatic handshake(input logic [63:0] npc);
    next_pc    = npc;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    next_pc    = '0;
  endtask

  initial begin
    int unsigned reqs;
    rst_n      = 1'b0;
    next_pc    = '0;
    inst_ready = 1'b0;
    imem_rdata = '0;
    imem_valid = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_out", out, 64'h0);
    chk("rst_pc4", PC4, 64'h4);
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    chk("rst_cause", {62'd0, fault_cause}, 64'd0);
    chk("rst_retired", retired_count, 64'd0);

    // First request lands in the second cycle after release
    rst_n = 1'b1;
    chk("idle_no_req", {63'd0, imem_req}, 64'd0);
    tick();
    chk("first_req", {63'd0, imem_req}, 64'd1);
    chk("first_addr", imem_addr, 64'h0);
    serve(0, 32'h0000_0013);
    expect_out();

    // Stall: outputs hold while inst_ready is low; imem_valid ignored in VALID
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {63'd0, inst_valid}, 64'd1);
      chk("stall_inst", {32'd0, inst}, 64'h13);
      chk("stall_out", out, 64'h0);
    end
    chk("stall_pc4", PC4, 64'h4);
    imem_valid = 1'b0;
    imem_rdata = '0;

    // Handshake to 0x40
    handshake(64'h40);
    chk("hs1_retired", retired_count, 64'd1);
    chk("hs1_addr", imem_addr, 64'h40);
    serve(0, 32'h00A0_0093);
    expect_out();

    // Response on the last permitted WAIT cycle beats the timeout
    handshake(64'h80);
    chk("hs2_retired", retired_count, 64'd2);
    serve(3, 32'h1234_5678);
    chk("edge_no_fault", {63'd0, fault}, 64'd0);
    expect_out();

    // PC at top of the address space: PC4 wraps to zero
    handshake(64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc4", PC4, 64'h0);
    serve(1, 32'h0000_0073);
    expect_out();

    // Misaligned next_pc: PC loads, terminal fault, no more requests
    handshake(64'h42);
    chk("mis_fault", {63'd0, fault}, 64'd1);
    chk("mis_cause", {62'd0, fault_cause}, 64'd1);
    chk("mis_out", out, 64'h42);
    chk("mis_inst_valid", {63'd0, inst_valid}, 64'd0);
    reqs = 0;
    inst_ready = 1'b1;
    imem_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (imem_req) reqs++;
      tick();
    end
    inst_ready = 1'b0;
    imem_valid = 1'b0;
    chk("mis_no_req", 64'(reqs), 64'd0);
    chk("mis_sticky", {63'd0, fault}, 64'd1);

    // Timeout after 4 silent WAIT cycles
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("to_addr", imem_addr, 64'h0);
    chk("to_req", {63'd0, imem_req}, 64'd1);
    chk("to_retired", retired_count, 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_waiting", {63'd0, fault}, 64'd0);
    end
    tick();
    chk("to_fault", {63'd0, fault}, 64'd1);
    chk("to_cause", {62'd0, fault_cause}, 64'd2);

    // Reset in the middle of WAIT; stale imem_valid after release is ignored
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("wr_async_req", {63'd0, imem_req}, 64'd0);
    chk("wr_async_fault", {63'd0, fault}, 64'd0);
    tick();
    rst_n      = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    chk("wr_idle_req", {63'd0, imem_req}, 64'd0);
    tick();
    chk("wr_fresh_req", {63'd0, imem_req}, 64'd1);
    chk("wr_fresh_addr", imem_addr, 64'h0);
    tick();
    imem_valid = 1'b0;
    imem_rdata = '0;
    chk("wr_late_ignored", {63'd0, inst_valid}, 64'd0);
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_0013;
    sb.push_back('{32'h0000_0013, 64'h0});
    tick();
    imem_valid = 1'b0;
    imem_rdata = '0;
    expect_out();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
